// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command front-end.
package alu_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Command kinds
    localparam logic [1:0] KIND_COMPUTE = 2'b00;
    localparam logic [1:0] KIND_LOAD    = 2'b01;
    localparam logic [1:0] KIND_CLEAR   = 2'b10;
    localparam logic [1:0] KIND_RSVD    = 2'b11;

    // ALU op codes
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_NOP    = 3'b011;
    localparam logic [2:0] OP_LOGIC0 = 3'b100;
    localparam logic [2:0] OP_LOGIC1 = 3'b101;
    localparam logic [2:0] OP_LOGIC2 = 3'b110;
    localparam logic [2:0] OP_LOGIC3 = 3'b111;

    // Width of the timing count T
    localparam int T_W = 4;

    // One queued command: kind in the upper bits, op in the lower bits
    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] op;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO with registered full/empty flags.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wr_data,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Next pointer/occupancy; flags are derived from the next count so they are registered
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are only meaningful where the pointers say so
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end: queues commands and sequences them into controller strobes and the T count.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAXT  = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_kind,
    input  logic [2:0]     cmd_op,
    input  logic           clr_SC,
    output logic           comp,
    output logic           load,
    output logic           clr,
    output logic [2:0]     op,
    output logic [T_W-1:0] T,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic           bad_cmd
);

    localparam logic [T_W-1:0] T_LAST = T_W'(MAXT);

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CMD_W-1:0] head_raw;
    cmd_t             head;

    state_t         state_q, state_d;
    logic [T_W-1:0] t_q, t_d;
    logic           comp_q, comp_d;
    logic           load_q, load_d;
    logic           clr_q, clr_d;
    logic [2:0]     op_q, op_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic           bad_cmd_q, bad_cmd_d;

    assign fifo_push = cmd_valid && !fifo_full;
    assign head      = head_raw;

    alu_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wr_data({cmd_kind, cmd_op}),
        .rd_data(head_raw),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Next-state and next-output decode; every output is a flop loaded from these values
    always_comb begin
        state_d   = state_q;
        t_d       = '0;
        comp_d    = 1'b0;
        load_d    = 1'b0;
        clr_d     = 1'b0;
        op_d      = op_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        bad_cmd_d = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                op_d = 3'b000;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = head.op;
                    case (head.kind)
                        KIND_COMPUTE: begin
                            state_d = ST_RUN;
                            comp_d  = 1'b1;
                        end
                        KIND_LOAD: begin
                            state_d = ST_STROBE;
                            load_d  = 1'b1;
                        end
                        KIND_CLEAR: begin
                            state_d = ST_STROBE;
                            clr_d   = 1'b1;
                        end
                        default: begin
                            state_d   = ST_GAP;
                            done_d    = 1'b1;
                            bad_cmd_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                // clr_SC during T=0 is stale from the previous command, so it is not honoured
                if ((t_q != '0) && clr_SC) begin
                    state_d = ST_GAP;
                    done_d  = 1'b1;
                end else if (t_q == T_LAST) begin
                    state_d   = ST_GAP;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    comp_d = 1'b1;
                    t_d    = t_q + T_W'(1);
                end
            end
            ST_STROBE: begin
                state_d = ST_GAP;
                done_d  = 1'b1;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                op_d    = 3'b000;
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = 3'b000;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            t_q       <= '0;
            comp_q    <= 1'b0;
            load_q    <= 1'b0;
            clr_q     <= 1'b0;
            op_q      <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            bad_cmd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            comp_q    <= comp_d;
            load_q    <= load_d;
            clr_q     <= clr_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            bad_cmd_q <= bad_cmd_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign comp      = comp_q;
    assign load      = load_q;
    assign clr       = clr_q;
    assign op        = op_q;
    assign T         = t_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign bad_cmd   = bad_cmd_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised bench for alu_cmd_sequencer against a transaction-level reference model.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int MAXT  = 15;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [2:0] cmd_op;
    logic       clr_SC;
    logic       comp, load, clr;
    logic [2:0] op;
    logic [3:0] T;
    logic       busy, done, timeout, bad_cmd;

    int checks;
    int errors;

    // Reference model: queued commands and the predicted per-cycle output records
    logic [4:0]  mq[$];
    logic [14:0] stream[$];
    logic [4:0]  pend[$];
    bit          from_pend;
    int          rand_left;
    logic [14:0] exp_rec;

    alu_cmd_sequencer #(
        .DEPTH(DEPTH),
        .MAXT (MAXT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_kind (cmd_kind),
        .cmd_op   (cmd_op),
        .clr_SC   (clr_SC),
        .comp     (comp),
        .load     (load),
        .clr      (clr),
        .op       (op),
        .T        (T),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .bad_cmd  (bad_cmd)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record layout: {cmd_ready, comp, load, clr, busy, done, timeout, bad_cmd, op[2:0], T[3:0]}
    function automatic logic [14:0] rec(bit c, bit l, bit k, bit b, bit d, bit to, bit bad,
                                        logic [2:0] o, logic [3:0] t);
        return {1'b0, c, l, k, b, d, to, bad, o, t};
    endfunction

    // op only carries meaning while a compute is running, so it is masked elsewhere
    function automatic logic [14:0] obsVec(bit mask_op);
        return {cmd_ready, comp, load, clr, busy, done, timeout, bad_cmd,
                (mask_op ? 3'b000 : op), T};
    endfunction

    // Cycle at which the controller model first drives clr_SC high for an op
    function automatic int clrTarget(logic [2:0] o);
        if (o == 3'b010) return 10;
        if (o == 3'b011) return 99;
        return 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] observed, input logic [14:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, observed, expected);
        end
    endtask

    // Expand one popped command into the output records it must produce, cycle by cycle
    task automatic expand(input logic [4:0] c);
        logic [1:0] k;
        logic [2:0] o;
        int last;
        k = c[4:3];
        o = c[2:0];
        case (k)
            2'b00: begin
                last = (o == 3'b010) ? 10 : ((o == 3'b011) ? MAXT : 3);
                for (int t = 0; t <= last; t++) stream.push_back(rec(1, 0, 0, 1, 0, 0, 0, o, 4'(t)));
                stream.push_back(rec(0, 0, 0, 1, 1, (o == 3'b011), 0, 3'b000, 4'd0));
            end
            2'b01: begin
                stream.push_back(rec(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'd0));
                stream.push_back(rec(0, 0, 0, 1, 1, 0, 0, 3'b000, 4'd0));
            end
            2'b10: begin
                stream.push_back(rec(0, 0, 1, 1, 0, 0, 0, 3'b000, 4'd0));
                stream.push_back(rec(0, 0, 0, 1, 1, 0, 0, 3'b000, 4'd0));
            end
            default: stream.push_back(rec(0, 0, 0, 1, 1, 0, 1, 3'b000, 4'd0));
        endcase
        stream.push_back(15'h0000);
    endtask

    // Advance the model across one rising edge using the inputs presented on that edge
    task automatic modelEdge();
        bit push_ok;
        push_ok = cmd_valid && (mq.size() < DEPTH);
        if (stream.size() == 0 && mq.size() != 0) expand(mq.pop_front());
        if (push_ok) begin
            mq.push_back({cmd_kind, cmd_op});
            if (from_pend) void'(pend.pop_front());
            else rand_left--;
        end
        exp_rec = (stream.size() != 0) ? stream.pop_front() : 15'h0000;
        exp_rec[14] = (mq.size() < DEPTH);
    endtask

    // Behavioural controller: raises clr_SC at the op's completion count, noise while not computing
    task automatic driveController();
        if (comp && T != 4'd0) clr_SC = (int'(T) == clrTarget(op));
        else if (!comp) clr_SC = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus();
        if (pend.size() != 0) begin
            cmd_valid = 1'b1;
            {cmd_kind, cmd_op} = pend[0];
            from_pend = 1'b1;
        end else if (rand_left > 0 && $urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b1;
            cmd_kind  = 2'($urandom_range(0, 3));
            cmd_op    = 3'($urandom_range(0, 7));
            from_pend = 1'b0;
        end else begin
            cmd_valid = 1'b0;
            cmd_kind  = 2'($urandom_range(0, 3));
            cmd_op    = 3'($urandom_range(0, 7));
            from_pend = 1'b0;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("cycle", obsVec(!exp_rec[13]), exp_rec);
        driveController();
        applyStimulus();
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        applyStimulus();
        while (!(pend.size() == 0 && mq.size() == 0 && stream.size() == 0 && rand_left == 0) && n < budget) begin
            stepCycle();
            n++;
        end
        repeat (2) stepCycle();
    endtask

    // Reset mid-cycle: outputs must clear with no clock edge, and all queued work is dropped
    task automatic asyncReset();
        #2;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        checkOutput("async_reset", obsVec(1'b0), 15'h4000);
        mq.delete();
        stream.delete();
        pend.delete();
        rand_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_kind  = 2'b00;
        cmd_op    = 3'b000;
        clr_SC    = 1'b0;
        from_pend = 1'b0;
        rand_left = 0;
        #1 reset = 1'b1;
        #1 checkOutput("reset_state", obsVec(1'b0), 15'h4000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] compute, booth, timeout");
        pend.push_back({2'b00, 3'b000});
        runUntilIdle(60);
        pend.push_back({2'b00, 3'b010});
        runUntilIdle(60);
        pend.push_back({2'b00, 3'b011});
        runUntilIdle(60);

        $display("[TB] back-pressure during booth");
        pend.push_back({2'b00, 3'b010});
        pend.push_back({2'b01, 3'b110});
        pend.push_back({2'b00, 3'b101});
        pend.push_back({2'b10, 3'b000});
        pend.push_back({2'b00, 3'b001});
        pend.push_back({2'b11, 3'b010});
        runUntilIdle(300);

        $display("[TB] load, clear, reserved");
        pend.push_back({2'b01, 3'b000});
        pend.push_back({2'b10, 3'b000});
        pend.push_back({2'b11, 3'b000});
        runUntilIdle(60);

        $display("[TB] random traffic");
        rand_left = 40;
        runUntilIdle(4000);

        $display("[TB] reset during activity");
        rand_left = 10;
        applyStimulus();
        repeat (25) stepCycle();
        asyncReset();
        runUntilIdle(20);
        pend.push_back({2'b00, 3'b100});
        runUntilIdle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the arithmetic logic processor, directly upstream of `controller`. It buffers incoming compute/load/clear commands in a small FIFO and presents them one at a time as `comp`/`load`/`clr`/`op` strobes. It generates the timing count `T` that the controller steps through. It ends each compute command when the controller raises `clr_SC`, or forces termination on timeout.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `MAXT`, 15: last legal `T` value; reaching it forces termination.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept (`count < DEPTH`).
- `cmd_kind` in 2: 00 compute, 01 load, 10 clear, 11 reserved.
- `cmd_op` in 3: ALU op for compute commands.
- `clr_SC` in 1: sequence-clear from controller.
- `comp`, `load`, `clr` out 1 each: strobes to controller.
- `op` out 3: current op, held constant for a whole command.
- `T` out 4: timing count.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse per retired command.
- `timeout` out 1: valid with `done`; command was ended by `MAXT`.
- `bad_cmd` out 1: valid with `done`; reserved kind was discarded.

## Operation
- Push happens on the edge where `cmd_valid && cmd_ready`. When full, `cmd_ready=0`, and a same-edge pop does not admit a push.
- IDLE: all strobes are 0 and `T=0`. If FIFO count ≠ 0, pop the head and latch `cur_kind`/`cur_op`:
  - compute goes to RUN.
  - load or clear goes to STROBE.
  - reserved goes to GAP with `bad_cmd=1`.
- RUN:
  - `comp=1`, `op=cur_op`.
  - `T` starts at 0 and increments by 1 each cycle.
  - `clr_SC` is ignored on the edge that ends the `T=0` cycle, because it still holds the previous command's value.
  - On a later edge, `clr_SC=1` moves to GAP.
  - Otherwise, the edge ending the `T==MAXT` cycle moves to GAP with `timeout=1`. This covers op 011, which never raises `clr_SC`.
- STROBE: `load` or `clr` is 1 for exactly one cycle, `T=0`, then GAP.
- GAP: all strobes are 0 for one cycle so the controller drops `we0`/`we1`. `done=1` along with the status flags. Next state is IDLE.
- `comp`, `load` and `clr` are never high together.
- `T` never wraps and never exceeds `MAXT`.

## Timing
- All outputs are registered. Reset values: `cmd_ready=1` and every other output 0. The FIFO is empty and the state is IDLE.
- The earliest pop is on the edge after the push. Strobes become visible in the cycle after the pop edge.
- Compute latency: RUN lasts from `T=0` to the first cycle in which `clr_SC` is sampled high.
  - ops 000/001/100–111 (controller raises `clr_SC` after T=2): 4 cycles, `T=0..3`.
  - op 010 Booth (raises after T=9): 11 cycles, `T=0..10`.
- Load/clear: 1 STROBE cycle plus 1 GAP cycle.
- Back-to-back commands: IDLE lasts one cycle between GAP and the next pop.
- Reset asserted mid-command: outputs go to 0 asynchronously, the in-flight and queued commands are lost, and no `done` is produced.

## Structure
- Shared package `alu_pkg` holds:
  - the state enum (IDLE, RUN, STROBE, GAP);
  - `cmd_kind` encodings;
  - op codes: ADD 000, SUB 001, MUL 010, NOP 011, 100/101/110/111 logic ops;
  - the `T` width constant.
- Sub-module `alu_cmd_fifo`:
  - parameterised synchronous FIFO with push/pop/count/full/empty and async reset;
  - entries are 5 bits (`kind`, `op`).
- The top level contains the FSM, the `T` counter and the output registers.

## Test plan
- Reset: assert `reset` during random activity → all outputs 0 and `cmd_ready=1` with no clock edge needed.
- Compute: push kind=00, op=000 with a behavioural controller model → `comp=1` for 4 cycles, `T` steps 0,1,2,3, then GAP, then `done=1` with `timeout=0`.
- Booth: push op=010 → RUN with `T=0..10`, `op` held at 010 throughout, then `done` is pulsed once.
- Timeout: push op=011 → `T` reaches 15, then `done=1` with `timeout=1`, then IDLE.
- Back-pressure: during a Booth run, push 5 commands → the 5th sees `cmd_ready=0` until the first pop. Commands then retire in FIFO order.
- Load then clear back-to-back, plus one kind=11 → sequence is `load=1` for 1 cycle, gap, `clr=1` for 1 cycle, gap, then `done` with `bad_cmd=1` and no strobes.
